// File: rtl/mul_cell_arbiter_if.sv
// Handshake bundles for mul_cell_arbiter: one per requester, plus the multiply/shift cell port.
// Requester bundle: request channel, response channel and the shared result data.

interface mul_req_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [1:0]       op;
    logic [1:0]       sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output valid, op, sign, a, b, rsp_ready,
        input  ready, rsp_valid, rsp_data
    );

    modport slave (
        input  valid, op, sign, a, b, rsp_ready,
        output ready, rsp_valid, rsp_data
    );
endinterface

// Port of the two-stage registered multiply/shift cell.
interface mul_cell_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             src1_signed;
    logic             src2_signed;
    logic             m_en;
    logic             a_en;
    logic             shift_right;
    logic             rotate;
    logic [WIDTH-1:0] result;

    modport master (
        output src1, src2, src1_signed, src2_signed, m_en, a_en, shift_right, rotate,
        input  result
    );

    modport slave (
        input  src1, src2, src1_signed, src2_signed, m_en, a_en, shift_right, rotate,
        output result
    );
endinterface

// File: rtl/mul_cell_arbiter.sv
// Shares one two-stage multiply/shift cell between two valid/ready requesters,
// tracking in-flight ops by tag and stalling the whole pipe on response backpressure.

module mul_cell_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter bit          RR_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    mul_req_if.slave   req0,
    mul_req_if.slave   req1,
    mul_cell_if.master mc
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    logic             vld_m;
    logic             vld_a;
    logic             tag_m;
    logic             tag_a;
    logic [1:0]       op_m;
    logic             rr_ptr;
    logic             advance;
    logic             rsp_ready_a;
    logic             grant_valid;
    logic             grant_id;
    logic [1:0]       sel_op;
    logic [1:0]       sel_sign;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Whole pipe holds while the head result waits on its owner.
    assign rsp_ready_a = tag_a ? req1.rsp_ready : req0.rsp_ready;
    assign advance     = !(vld_a && !rsp_ready_a);

    // Grant selection: contention resolved by rr_ptr (or req0 when fixed priority).
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (advance && !reset) begin
            if (req0.valid && req1.valid) begin
                grant_valid = 1'b1;
                grant_id    = RR_EN & rr_ptr;
            end else if (req0.valid || req1.valid) begin
                grant_valid = 1'b1;
                grant_id    = req1.valid;
            end
        end
    end

    assign sel_op   = grant_id ? req1.op   : req0.op;
    assign sel_sign = grant_id ? req1.sign : req0.sign;
    assign sel_a    = grant_id ? req1.a    : req0.a;
    assign sel_b    = grant_id ? req1.b    : req0.b;

    // Issue stage: shifts become a multiply by a one-hot power of two.
    always_comb begin
        req0.ready     = grant_valid && !grant_id;
        req1.ready     = grant_valid && grant_id;
        mc.src1        = '0;
        mc.src2        = '0;
        mc.src1_signed = 1'b0;
        mc.src2_signed = 1'b0;
        if (grant_valid) begin
            mc.src1 = sel_a;
            if (sel_op == OP_MUL) begin
                mc.src2        = sel_b;
                mc.src1_signed = sel_sign[0];
                mc.src2_signed = sel_sign[1];
            end else begin
                mc.src2 = WIDTH'(1) << sel_b[SHAMT_W-1:0];
            end
        end
    end

    assign mc.m_en        = advance;
    assign mc.a_en        = advance;
    assign mc.shift_right = vld_m && ((op_m == OP_SHR) || (op_m == OP_ROTR));
    assign mc.rotate      = vld_m && (op_m == OP_ROTR);

    assign req0.rsp_valid = vld_a && !tag_a;
    assign req1.rsp_valid = vld_a && tag_a;
    assign req0.rsp_data  = mc.result;
    assign req1.rsp_data  = mc.result;

    // Pipeline tracking and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_m  <= 1'b0;
            vld_a  <= 1'b0;
            tag_m  <= 1'b0;
            tag_a  <= 1'b0;
            op_m   <= OP_MUL;
            rr_ptr <= 1'b0;
        end else if (advance) begin
            vld_m <= grant_valid;
            tag_m <= grant_id;
            op_m  <= sel_op;
            vld_a <= vld_m;
            tag_a <= tag_m;
            if (grant_valid) begin
                rr_ptr <= !grant_id;
            end
        end
    end

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Directed bench for mul_cell_arbiter: round-robin instance with a behavioural cell model,
// plus a fixed-priority instance for the priority check.

module tb_mul_cell_arbiter;

    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mul_req_if  #(.WIDTH(W)) rq0 ();
    mul_req_if  #(.WIDTH(W)) rq1 ();
    mul_cell_if #(.WIDTH(W)) cl  ();
    mul_req_if  #(.WIDTH(W)) fq0 ();
    mul_req_if  #(.WIDTH(W)) fq1 ();
    mul_cell_if #(.WIDTH(W)) fcl ();

    mul_cell_arbiter #(.WIDTH(W), .SHAMT_W(5), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .req0(rq0), .req1(rq1), .mc(cl)
    );

    mul_cell_arbiter #(.WIDTH(W), .SHAMT_W(5), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .req0(fq0), .req1(fq1), .mc(fcl)
    );

    // Cell model: low product word, logical right shift, or rotate right by log2(src2).
    function automatic logic [W-1:0] cell_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sr, input logic rot);
        logic [2*W-1:0] p;
        int             n;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        n = 0;
        for (int i = 0; i < W; i++) if (b[i]) n = i;
        if (rot) return (a >> n) | (a << (W - n));
        if (sr)  return a >> n;
        return p[W-1:0];
    endfunction

    logic [W-1:0] ca = '0, cb = '0, cres = '0;
    logic [W-1:0] fa = '0, fb = '0, fres = '0;

    always @(posedge clk) begin
        if (cl.m_en) begin
            ca <= cl.src1;
            cb <= cl.src2;
        end
        if (cl.a_en) cres <= cell_eval(ca, cb, cl.shift_right, cl.rotate);
        if (fcl.m_en) begin
            fa <= fcl.src1;
            fb <= fcl.src2;
        end
        if (fcl.a_en) fres <= cell_eval(fa, fb, fcl.shift_right, fcl.rotate);
    end

    assign cl.result  = cres;
    assign fcl.result = fres;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input logic [1:0] op,
                           input logic [1:0] sg, input logic [W-1:0] a, input logic [W-1:0] b);
        case (idx)
            0: begin rq0.valid = v; rq0.op = op; rq0.sign = sg; rq0.a = a; rq0.b = b; end
            1: begin rq1.valid = v; rq1.op = op; rq1.sign = sg; rq1.a = a; rq1.b = b; end
            2: begin fq0.valid = v; fq0.op = op; fq0.sign = sg; fq0.a = a; fq0.b = b; end
            default: begin fq1.valid = v; fq1.op = op; fq1.sign = sg; fq1.a = a; fq1.b = b; end
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'b00, 2'b00, '0, '0);
        rq0.rsp_ready = 1'b1; rq1.rsp_ready = 1'b1;
        fq0.rsp_ready = 1'b1; fq1.rsp_ready = 1'b1;

        // Reset: a pending request is not granted and the cell is enabled.
        set_req(0, 1'b1, 2'b00, 2'b00, 32'd7, 32'd6);
        @(negedge clk); #1;
        check("rst_ready0", 32'(rq0.ready), 0);
        check("rst_rsp0", 32'(rq0.rsp_valid), 0);
        check("rst_rsp1", 32'(rq1.rsp_valid), 0);
        check("rst_m_en", 32'(cl.m_en), 1);
        check("rst_a_en", 32'(cl.a_en), 1);
        check("rst_src1", cl.src1, 0);
        check("rst_sr", 32'(cl.shift_right), 0);

        // Single MUL 7*6 from req0.
        @(negedge clk); reset = 1'b0; #1;
        check("t1_ready0", 32'(rq0.ready), 1);
        check("t1_src1", cl.src1, 7);
        check("t1_src2", cl.src2, 6);
        @(negedge clk); set_req(0, 1'b0, 2'b00, 2'b00, '0, '0); #1;
        check("t1_ready0_off", 32'(rq0.ready), 0);
        check("t1_rsp0_early", 32'(rq0.rsp_valid), 0);
        @(negedge clk); #1;
        check("t1_rsp0", 32'(rq0.rsp_valid), 1);
        check("t1_data", rq0.rsp_data, 42);
        check("t1_rsp1", 32'(rq1.rsp_valid), 0);
        @(negedge clk); #1;
        check("t1_pulse", 32'(rq0.rsp_valid), 0);

        // Signed MUL then ROTR back to back from req1.
        @(negedge clk); set_req(1, 1'b1, 2'b00, 2'b11, 32'hFFFF_FFFD, 32'd5); #1;
        check("t3_ready1", 32'(rq1.ready), 1);
        check("t3_s1", 32'(cl.src1_signed), 1);
        check("t3_s2", 32'(cl.src2_signed), 1);
        @(negedge clk); set_req(1, 1'b1, 2'b11, 2'b11, 32'h8000_0001, 32'd1); #1;
        check("t3_ready1_rot", 32'(rq1.ready), 1);
        check("t3_src2_rot", cl.src2, 2);
        check("t3_s1_rot", 32'(cl.src1_signed), 0);
        check("t3_sr_mul", 32'(cl.shift_right), 0);
        @(negedge clk); set_req(1, 1'b0, 2'b00, 2'b00, '0, '0); #1;
        check("t3_sr_rot", 32'(cl.shift_right), 1);
        check("t3_rot", 32'(cl.rotate), 1);
        check("t3_rsp1_mul", 32'(rq1.rsp_valid), 1);
        check("t3_data_mul", rq1.rsp_data, 32'hFFFF_FFF1);
        @(negedge clk); #1;
        check("t3_rsp1_rot", 32'(rq1.rsp_valid), 1);
        check("t3_data_rot", rq1.rsp_data, 32'hC000_0000);
        @(negedge clk); #1;
        check("t3_idle", 32'(rq1.rsp_valid), 0);

        // Both requesting continuously: grants alternate starting at req0.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                set_req(0, 1'b1, 2'b01, 2'b00, 32'd3, 32'd4);
                set_req(1, 1'b1, 2'b10, 2'b00, 32'hF00, 32'd8);
            end else begin
                set_req(0, 1'b0, 2'b00, 2'b00, '0, '0);
                set_req(1, 1'b0, 2'b00, 2'b00, '0, '0);
            end
            #1;
            check("t2_ready0", 32'(rq0.ready), 32'(k < 4 && k % 2 == 0));
            check("t2_ready1", 32'(rq1.ready), 32'(k < 4 && k % 2 == 1));
            if (k >= 2) begin
                check("t2_rsp0", 32'(rq0.rsp_valid), 32'(k % 2 == 0));
                check("t2_rsp1", 32'(rq1.rsp_valid), 32'(k % 2 == 1));
                check("t2_data", rq0.rsp_data, (k % 2 == 0) ? 32'h30 : 32'hF);
            end
        end

        // Backpressure on req0 with two ops in flight.
        @(negedge clk); set_req(0, 1'b1, 2'b00, 2'b00, 32'd10, 32'd11); rq0.rsp_ready = 1'b0; #1;
        check("t4_ready0_a", 32'(rq0.ready), 1);
        @(negedge clk); set_req(0, 1'b0, 2'b00, 2'b00, '0, '0);
        set_req(1, 1'b1, 2'b00, 2'b00, 32'd2, 32'd3); #1;
        check("t4_ready1_b", 32'(rq1.ready), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_req(0, 1'b1, 2'b00, 2'b00, 32'd4, 32'd5);
            set_req(1, 1'b1, 2'b00, 2'b00, 32'd3, 32'd7);
            #1;
            check("t4_m_en", 32'(cl.m_en), 0);
            check("t4_a_en", 32'(cl.a_en), 0);
            check("t4_ready0", 32'(rq0.ready), 0);
            check("t4_ready1", 32'(rq1.ready), 0);
            check("t4_rsp0", 32'(rq0.rsp_valid), 1);
            check("t4_rsp1", 32'(rq1.rsp_valid), 0);
            check("t4_data", rq0.rsp_data, 110);
        end
        @(negedge clk); rq0.rsp_ready = 1'b1; #1;
        check("t4_resume_m_en", 32'(cl.m_en), 1);
        check("t4_resume_ready0", 32'(rq0.ready), 1);
        check("t4_resume_ready1", 32'(rq1.ready), 0);
        check("t4_resume_data", rq0.rsp_data, 110);
        @(negedge clk); set_req(0, 1'b0, 2'b00, 2'b00, '0, '0); #1;
        check("t4_ready1_d", 32'(rq1.ready), 1);
        check("t4_rsp1_b", 32'(rq1.rsp_valid), 1);
        check("t4_data_b", rq1.rsp_data, 6);
        @(negedge clk); set_req(1, 1'b0, 2'b00, 2'b00, '0, '0); #1;
        check("t4_rsp0_c", 32'(rq0.rsp_valid), 1);
        check("t4_data_c", rq0.rsp_data, 20);
        @(negedge clk); #1;
        check("t4_rsp1_d", 32'(rq1.rsp_valid), 1);
        check("t4_data_d", rq1.rsp_data, 21);
        @(negedge clk); #1;
        check("t4_drained", 32'(rq0.rsp_valid | rq1.rsp_valid), 0);

        // Reset with both stages occupied drops the in-flight ops.
        @(negedge clk); set_req(0, 1'b1, 2'b00, 2'b00, 32'd9, 32'd9); #1;
        check("t6_ready0_a", 32'(rq0.ready), 1);
        @(negedge clk); set_req(0, 1'b1, 2'b00, 2'b00, 32'd2, 32'd2); #1;
        check("t6_ready0_b", 32'(rq0.ready), 1);
        @(negedge clk); set_req(0, 1'b0, 2'b00, 2'b00, '0, '0); reset = 1'b1; #1;
        check("t6_rsp0_rst", 32'(rq0.rsp_valid), 0);
        check("t6_m_en_rst", 32'(cl.m_en), 1);
        @(negedge clk); reset = 1'b0; #1;
        check("t6_rsp0_after", 32'(rq0.rsp_valid), 0);
        check("t6_rsp1_after", 32'(rq1.rsp_valid), 0);
        @(negedge clk); set_req(1, 1'b1, 2'b00, 2'b00, 32'd12, 32'd12); #1;
        check("t6_rsp0_late", 32'(rq0.rsp_valid), 0);
        check("t6_ready1", 32'(rq1.ready), 1);
        @(negedge clk); set_req(1, 1'b0, 2'b00, 2'b00, '0, '0); #1;
        @(negedge clk); #1;
        check("t6_rsp1", 32'(rq1.rsp_valid), 1);
        check("t6_data", rq1.rsp_data, 144);
        check("t6_rsp0", 32'(rq0.rsp_valid), 0);

        // Fixed-priority instance: req0 always wins while valid.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_req(2, 1'b1 && (k < 3), 2'b00, 2'b00, 32'd1, 32'd1);
            set_req(3, 1'b1 && (k < 4), 2'b00, 2'b00, 32'd2, 32'd2);
            #1;
            check("t5_ready0", 32'(fq0.ready), 32'(k < 3));
            check("t5_ready1", 32'(fq1.ready), 32'(k == 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
